// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared opcodes, flag indices, commit classes and WB FSM states.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int FLAG_W = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_MOVI = 4'b0110;
   localparam logic [3:0] OP_MOV  = 4'b0111;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_STR  = 4'b1100;
   localparam logic [3:0] OP_LDR  = 4'b1101;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PIPE = 2'd1,
      ST_MEM  = 2'd2
   } wb_state_e;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ALU  = 3'd1,
      CLS_MOV  = 3'd2,
      CLS_CMP  = 3'd3,
      CLS_LDR  = 3'd4,
      CLS_STR  = 3'd5
   } wb_class_e;

   function automatic wb_class_e op_class(input logic [3:0] op);
      wb_class_e cls;
      cls = CLS_NONE;
      if (op <= OP_XOR)                    cls = CLS_ALU;
      else if (op == OP_MOVI || op == OP_MOV) cls = CLS_MOV;
      else if (op == OP_CMP)               cls = CLS_CMP;
      else if (op == OP_LDR)               cls = CLS_LDR;
      else if (op == OP_STR)               cls = CLS_STR;
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file
// Brief  : Architectural register file, one write port, combinational reads
//          (two operand ports plus one store-data port), sync reset clear.
// Rev    : 1.0  initial release
// ============================================================================
module reg_file #(
   parameter  int NUM_REGS = 16,
   parameter  int DATA_W   = 32,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   input  logic [AW-1:0]     raddr_c,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];
   assign rdata_c = regs_q[raddr_c];

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module : writeback_unit
// Brief  : Commit stage: WB register, register file, status flags, memory
//          req/ack port. Build option WB_FORWARD_EN bypasses the committing
//          write onto the operand read ports.
// Rev    : 1.0  initial release
// ============================================================================
module writeback_unit
   import cpu_pkg::*;
#(
   parameter  int NUM_REGS = 16,
   parameter  int DATA_W   = 32,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic              cond_met,
   input  logic [3:0]        opcode,
   input  logic              s_bit,
   input  logic [AW-1:0]     rd,
   input  logic [AW-1:0]     rs1_addr,
   input  logic [AW-1:0]     rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [FLAG_W-1:0] status_flags,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       retire_count
);

   wb_state_e         state_q, state_d;
   logic              wb_valid_q, wb_valid_d;
   logic [3:0]        wb_op_q, wb_op_d;
   logic [AW-1:0]     wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [FLAG_W-1:0] wb_flags_q, wb_flags_d;
   logic              wb_s_q, wb_s_d;
   logic              wb_cond_q, wb_cond_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [31:0]       retire_q, retire_d;

   wb_class_e         w_in_cls, w_wb_cls;
   logic              w_accept, w_in_mem, w_commit, w_wr_en;
   logic [DATA_W-1:0] w_wr_data, w_st_data;
   logic [DATA_W-1:0] w_rf_rs1, w_rf_rs2, w_rf_st;

   reg_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .we      (w_wr_en),
      .waddr   (wb_rd_q),
      .wdata   (w_wr_data),
      .raddr_a (rs1_addr),
      .raddr_b (rs2_addr),
      .raddr_c (rd),
      .rdata_a (w_rf_rs1),
      .rdata_b (w_rf_rs2),
      .rdata_c (w_rf_st)
   );

   always_comb begin
      w_in_cls  = op_class(opcode);
      w_wb_cls  = op_class(wb_op_q);
      in_ready  = (state_q != ST_MEM) || mem_ack;
      w_accept  = in_valid && in_ready;
      w_in_mem  = cond_met && (w_in_cls == CLS_LDR || w_in_cls == CLS_STR);
      // A memory op only retires in its ack cycle; everything else one cycle after capture
      w_commit  = wb_valid_q && wb_cond_q && (w_wb_cls != CLS_NONE) &&
                  ((state_q != ST_MEM) || mem_ack);
      w_wr_en   = w_commit && (w_wb_cls == CLS_ALU || w_wb_cls == CLS_MOV ||
                               w_wb_cls == CLS_LDR);
      w_wr_data = (w_wb_cls == CLS_LDR) ? mem_rdata : wb_data_q;
      // Store data must see a write retiring on the same edge the store is captured
      w_st_data = (w_wr_en && wb_rd_q == rd) ? w_wr_data : w_rf_st;
`ifdef WB_FORWARD_EN
      rs1_data  = (w_wr_en && wb_rd_q == rs1_addr) ? w_wr_data : w_rf_rs1;
      rs2_data  = (w_wr_en && wb_rd_q == rs2_addr) ? w_wr_data : w_rf_rs2;
`else
      rs1_data  = w_rf_rs1;
      rs2_data  = w_rf_rs2;
`endif
   end

   always_comb begin
      state_d     = state_q;
      wb_valid_d  = wb_valid_q;
      wb_op_d     = wb_op_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      wb_flags_d  = wb_flags_q;
      wb_s_d      = wb_s_q;
      wb_cond_d   = wb_cond_q;
      flags_d     = flags_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      retire_d    = retire_q;

      if (in_ready) begin
         wb_valid_d  = in_valid;
         state_d     = !in_valid ? ST_IDLE : (w_in_mem ? ST_MEM : ST_PIPE);
         mem_req_d   = 1'b0;
         mem_we_d    = 1'b0;
         mem_addr_d  = '0;
         mem_wdata_d = '0;
         if (w_accept) begin
            wb_op_d    = opcode;
            wb_rd_d    = rd;
            wb_data_d  = alu_out;
            wb_flags_d = alu_flags;
            wb_s_d     = s_bit;
            wb_cond_d  = cond_met;
            if (w_in_mem) begin
               mem_req_d   = 1'b1;
               mem_we_d    = (w_in_cls == CLS_STR);
               mem_addr_d  = alu_out;
               mem_wdata_d = (w_in_cls == CLS_STR) ? w_st_data : '0;
            end
         end
      end

      if (w_commit && (w_wb_cls == CLS_CMP || (w_wb_cls == CLS_ALU && wb_s_q)))
         flags_d = wb_flags_q;
      if (w_commit)
         retire_d = retire_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wb_valid_q  <= 1'b0;
         wb_op_q     <= OP_NOP;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         wb_flags_q  <= '0;
         wb_s_q      <= 1'b0;
         wb_cond_q   <= 1'b0;
         flags_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         retire_q    <= '0;
      end else begin
         state_q     <= state_d;
         wb_valid_q  <= wb_valid_d;
         wb_op_q     <= wb_op_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         wb_flags_q  <= wb_flags_d;
         wb_s_q      <= wb_s_d;
         wb_cond_q   <= wb_cond_d;
         flags_q     <= flags_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         retire_q    <= retire_d;
      end
   end

   assign status_flags = flags_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign retire_count = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_writeback_unit
// Brief  : Directed table-driven bench for writeback_unit (WB_FORWARD_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags;
   logic        cond_met;
   logic [3:0]  opcode;
   logic        s_bit;
   logic [3:0]  rd;
   logic [3:0]  rs1_addr;
   logic [3:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [3:0]  status_flags;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] retire_count;

   int n_cmp = 0;
   int n_err = 0;

   writeback_unit dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_out      (alu_out),
      .alu_flags    (alu_flags),
      .cond_met     (cond_met),
      .opcode       (opcode),
      .s_bit        (s_bit),
      .rd           (rd),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .status_flags (status_flags),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [31:0] data;
      logic [3:0]  fl;
      logic        s;
      logic        c;
      logic [31:0] exp_reg;
      logic [3:0]  exp_fl;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_op(input logic [3:0] op, input logic [3:0] r, input logic [31:0] d,
                           input logic [3:0] f, input logic s, input logic c);
      in_valid  = 1'b1;
      opcode    = op;
      rd        = r;
      alu_out   = d;
      alu_flags = f;
      s_bit     = s;
      cond_met  = c;
   endtask

   initial begin
      // op, rd, alu_out, flags, s, cond -> reg[rd], status_flags, retire_count
      vecs[0] = '{4'h0, 4'd3,  32'h0000_0015, 4'b0000, 1'b0, 1'b1, 32'h0000_0015, 4'b0000, 32'd1};
      vecs[1] = '{4'h1, 4'd6,  32'h0000_0009, 4'b0100, 1'b1, 1'b1, 32'h0000_0009, 4'b0100, 32'd2};
      vecs[2] = '{4'hB, 4'd6,  32'h0000_0077, 4'b1000, 1'b0, 1'b1, 32'h0000_0009, 4'b1000, 32'd3};
      vecs[3] = '{4'h6, 4'd2,  32'h0000_0055, 4'b1111, 1'b1, 1'b1, 32'h0000_0055, 4'b1000, 32'd4};
      vecs[4] = '{4'h5, 4'd7,  32'h0000_1234, 4'b0010, 1'b1, 1'b0, 32'h0000_0000, 4'b1000, 32'd4};
      vecs[5] = '{4'hF, 4'd3,  32'h0000_FFFF, 4'b0001, 1'b1, 1'b1, 32'h0000_0015, 4'b1000, 32'd4};
      vecs[6] = '{4'h7, 4'd0,  32'hA5A5_A5A5, 4'b0000, 1'b0, 1'b1, 32'hA5A5_A5A5, 4'b1000, 32'd5};
      vecs[7] = '{4'h2, 4'd15, 32'hFFFF_FFFF, 4'b0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0010, 32'd6};
      vecs[8] = '{4'hB, 4'd1,  32'h0000_0000, 4'b0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0010, 32'd6};

      rst = 1'b1; in_valid = 1'b0; alu_out = '0; alu_flags = '0; cond_met = 1'b0;
      opcode = 4'hF; s_bit = 1'b0; rd = '0; rs1_addr = '0; rs2_addr = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_flags", {28'd0, status_flags}, 32'd0);
      check("rst_count", retire_count, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_rs1", rs1_data, 32'd0);

      for (int i = 0; i < 9; i++) begin
         drive_op(vecs[i].op, vecs[i].rd, vecs[i].data, vecs[i].fl, vecs[i].s, vecs[i].c);
         tick();
         in_valid = 1'b0;
         tick();
         rs1_addr = vecs[i].rd;
         rs2_addr = vecs[i].rd;
         #1;
         check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].exp_reg);
         check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].exp_reg);
         check($sformatf("vec%0d_flags", i), {28'd0, status_flags}, {28'd0, vecs[i].exp_fl});
         check($sformatf("vec%0d_count", i), retire_count, vecs[i].exp_cnt);
      end

      // Back-to-back ALU ops and read of the in-flight destination
      drive_op(4'h0, 4'd4, 32'd7, 4'b0000, 1'b0, 1'b1);
      tick();
      drive_op(4'h0, 4'd8, 32'd8, 4'b0000, 1'b0, 1'b1);
      rs1_addr = 4'd4;
      #1;
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef WB_FORWARD_EN
      check("fwd_rs1", rs1_data, 32'd7);
`else
      check("nofwd_rs1", rs1_data, 32'd0);
`endif
      tick();
      in_valid = 1'b0;
      tick();
      rs1_addr = 4'd4; rs2_addr = 4'd8;
      #1;
      check("b2b_r4", rs1_data, 32'd7);
      check("b2b_r8", rs2_data, 32'd8);
      check("b2b_count", retire_count, 32'd8);

      // LDR with three wait cycles
      drive_op(4'hD, 4'd5, 32'h100, 4'b0000, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      check("ldr_req", {31'd0, mem_req}, 32'd1);
      check("ldr_we", {31'd0, mem_we}, 32'd0);
      check("ldr_addr", mem_addr, 32'h100);
      check("ldr_wait0_ready", {31'd0, in_ready}, 32'd0);
      for (int w = 1; w < 3; w++) begin
         tick();
         check($sformatf("ldr_wait%0d_req", w), {31'd0, mem_req}, 32'd1);
         check($sformatf("ldr_wait%0d_ready", w), {31'd0, in_ready}, 32'd0);
         check($sformatf("ldr_wait%0d_addr", w), mem_addr, 32'h100);
      end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; rs1_addr = 4'd5;
      #1;
      check("ldr_ack_ready", {31'd0, in_ready}, 32'd1);
      check("ldr_ack_count", retire_count, 32'd8);
`ifdef WB_FORWARD_EN
      check("ldr_fwd_rs1", rs1_data, 32'hDEAD_BEEF);
`else
      check("ldr_nofwd_rs1", rs1_data, 32'd0);
`endif
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      check("ldr_done_req", {31'd0, mem_req}, 32'd0);
      check("ldr_r5", rs1_data, 32'hDEAD_BEEF);
      check("ldr_count", retire_count, 32'd9);

      // Annulled STR, with a stray ack that must be ignored
      drive_op(4'hC, 4'd2, 32'h40, 4'b0000, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0; mem_ack = 1'b1;
      #1;
      check("str_annul_req", {31'd0, mem_req}, 32'd0);
      check("str_annul_ready", {31'd0, in_ready}, 32'd1);
      tick();
      mem_ack = 1'b0;
      #1;
      check("str_annul_count", retire_count, 32'd9);
      check("str_annul_req2", {31'd0, mem_req}, 32'd0);

      // STR with ack on first request cycle, new ADD captured on the ack edge
      drive_op(4'hC, 4'd2, 32'h40, 4'b0000, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      check("str_req", {31'd0, mem_req}, 32'd1);
      check("str_we", {31'd0, mem_we}, 32'd1);
      check("str_addr", mem_addr, 32'h40);
      check("str_wdata", mem_wdata, 32'h55);
      check("str_ready_lo", {31'd0, in_ready}, 32'd0);
      mem_ack = 1'b1;
      drive_op(4'h0, 4'd10, 32'h33, 4'b0000, 1'b0, 1'b1);
      #1;
      check("str_ack_ready", {31'd0, in_ready}, 32'd1);
      tick();
      mem_ack = 1'b0; in_valid = 1'b0;
      #1;
      check("str_done_req", {31'd0, mem_req}, 32'd0);
      check("str_done_we", {31'd0, mem_we}, 32'd0);
      check("str_count", retire_count, 32'd10);
      tick();
      rs1_addr = 4'd10;
      #1;
      check("post_ack_r10", rs1_data, 32'h33);
      check("post_ack_count", retire_count, 32'd11);

      // Reset while a load is outstanding
      drive_op(4'hD, 4'd9, 32'h200, 4'b0000, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      check("rstmem_req_hi", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      #1;
      check("rstmem_req", {31'd0, mem_req}, 32'd0);
      check("rstmem_ready", {31'd0, in_ready}, 32'd1);
      check("rstmem_count", retire_count, 32'd0);
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678; rs1_addr = 4'd9;
      tick();
      mem_ack = 1'b0;
      #1;
      check("rstmem_r9", rs1_data, 32'd0);
      check("rstmem_count2", retire_count, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
